// File: rtl/calc_seq_core.sv
// calc_seq_core: sequential add/sub/mul/div calculator with a BCD result.
// Operands are clipped to OP_MAX when a start is accepted in IDLE. Mul is a
// shift-add unit and div is a restoring divider, each taking OP_W cycles.
// The result is then converted to packed BCD by a sequential double-dabble
// that takes 2*OP_W cycles.
// Ports:
//   iCLK, iRST      clock and synchronous active-high reset
//   iSTART          start request, sampled only in IDLE
//   iA, iB, iOP     raw operands and opcode (00 add, 01 sub, 10 mul, 11 div)
//   oBUSY, oDONE    busy level (EXEC/CONV/DONE) and one-cycle completion pulse
//   oRESULT, oREM   binary magnitude (quotient for div) and div remainder
//   oBCD            packed BCD of oRESULT, all 4'hF on divide by zero
//   oNEG, oERR      negative sub result, divide by zero
module calc_seq_core #(
  parameter int unsigned OP_W       = 7,
  parameter int unsigned OP_MAX     = 99,
  parameter int unsigned RES_DIGITS = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iSTART,
  input  logic [OP_W-1:0]         iA,
  input  logic [OP_W-1:0]         iB,
  input  logic [1:0]              iOP,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [2*OP_W-1:0]       oRESULT,
  output logic [OP_W-1:0]         oREM,
  output logic [4*RES_DIGITS-1:0] oBCD,
  output logic                    oNEG,
  output logic                    oERR
);

  localparam int unsigned R_W   = 2 * OP_W;
  localparam int unsigned BCD_W = 4 * RES_DIGITS;
  localparam int unsigned CNT_W = $clog2(R_W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [R_W-1:0]     a_q, a_d;         // A / multiplicand / dividend-quotient shifter
  logic [OP_W-1:0]    b_q, b_d;         // B / multiplier shifter / divisor
  logic [1:0]         op_q, op_d;
  logic [R_W-1:0]     acc_q, acc_d;     // product accumulator
  logic [OP_W-1:0]    wrem_q, wrem_d;   // working remainder
  logic               wneg_q, wneg_d;
  logic               werr_q, werr_d;
  logic [R_W-1:0]     r_q, r_d;         // final binary result awaiting publication
  logic [R_W-1:0]     bin_q, bin_d;     // double-dabble binary shifter
  logic [BCD_W-1:0]   dab_q, dab_d;     // double-dabble BCD shifter
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [R_W-1:0]     result_q, result_d;
  logic [OP_W-1:0]    rem_q, rem_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;

  logic [OP_W-1:0]    a_clip_c, b_clip_c;
  logic [R_W-1:0]     mul_acc_c;
  logic [OP_W:0]      div_try_c;
  logic               div_ge_c;
  logic [OP_W-1:0]    div_rem_c;
  logic [R_W-1:0]     quo_c;
  logic               last_step_c;
  logic [BCD_W-1:0]   dab_adj_c;
  logic [BCD_W-1:0]   dab_next_c;
  logic               exec_fin_c;
  logic [R_W-1:0]     exec_res_c;

  // Datapath helpers for one mul / div step and operand clipping
  always_comb begin
    a_clip_c    = (iA > OP_W'(OP_MAX)) ? OP_W'(OP_MAX) : iA;
    b_clip_c    = (iB > OP_W'(OP_MAX)) ? OP_W'(OP_MAX) : iB;
    mul_acc_c   = acc_q + (b_q[0] ? a_q : '0);
    // Restoring step: bring in the next dividend MSB, subtract if it fits
    div_try_c   = {wrem_q, a_q[OP_W-1]};
    div_ge_c    = (div_try_c >= {1'b0, b_q});
    div_rem_c   = div_ge_c ? OP_W'(div_try_c - {1'b0, b_q}) : OP_W'(div_try_c);
    quo_c       = {a_q[R_W-2:0], div_ge_c};
    last_step_c = (cnt_q == CNT_W'(OP_W - 1));
  end

  // Double-dabble: add 3 to every digit >= 5, then shift in the next bit
  always_comb begin
    dab_adj_c = dab_q;
    for (int unsigned i = 0; i < RES_DIGITS; i++) begin
      if (dab_q[4*i +: 4] >= 4'd5) begin
        dab_adj_c[4*i +: 4] = dab_q[4*i +: 4] + 4'd3;
      end
    end
    dab_next_c = BCD_W'({dab_adj_c, bin_q[R_W-1]});
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    acc_d      = acc_q;
    wrem_d     = wrem_q;
    wneg_d     = wneg_q;
    werr_d     = werr_q;
    r_d        = r_q;
    bin_d      = bin_q;
    dab_d      = dab_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    rem_d      = rem_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    err_d      = err_q;
    exec_fin_c = 1'b0;
    exec_res_c = '0;

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          a_d     = R_W'(a_clip_c);
          b_d     = b_clip_c;
          op_d    = iOP;
          acc_d   = '0;
          wrem_d  = '0;
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        wneg_d = 1'b0;
        werr_d = 1'b0;
        case (op_q)
          OP_ADD: begin
            exec_fin_c = 1'b1;
            exec_res_c = a_q + R_W'(b_q);
          end
          OP_SUB: begin
            exec_fin_c = 1'b1;
            if (a_q[OP_W-1:0] < b_q) begin
              exec_res_c = R_W'(b_q - a_q[OP_W-1:0]);
              wneg_d     = 1'b1;
            end else begin
              exec_res_c = R_W'(a_q[OP_W-1:0] - b_q);
            end
          end
          OP_MUL: begin
            acc_d = mul_acc_c;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step_c) begin
              exec_fin_c = 1'b1;
              exec_res_c = mul_acc_c;
            end
          end
          default: begin
            if (b_q == '0) begin
              exec_fin_c = 1'b1;
              werr_d     = 1'b1;
              wrem_d     = '0;
            end else begin
              a_d    = quo_c;
              wrem_d = div_rem_c;
              cnt_d  = cnt_q + CNT_W'(1);
              if (last_step_c) begin
                exec_fin_c = 1'b1;
                exec_res_c = R_W'(quo_c[OP_W-1:0]);
              end
            end
          end
        endcase
        if (exec_fin_c) begin
          r_d     = exec_res_c;
          bin_d   = exec_res_c;
          dab_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        dab_d = dab_next_c;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(R_W - 1)) begin
          // Publish every result field together on DONE entry
          result_d = r_q;
          rem_d    = wrem_q;
          neg_d    = wneg_q;
          err_d    = werr_q;
          bcd_d    = werr_q ? '1 : dab_next_c;
          state_d  = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      wrem_q   <= '0;
      wneg_q   <= 1'b0;
      werr_q   <= 1'b0;
      r_q      <= '0;
      bin_q    <= '0;
      dab_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      wrem_q   <= wrem_d;
      wneg_q   <= wneg_d;
      werr_q   <= werr_d;
      r_q      <= r_d;
      bin_q    <= bin_d;
      dab_q    <= dab_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign oBUSY   = busy_q;
  assign oDONE   = done_q;
  assign oRESULT = result_q;
  assign oREM    = rem_q;
  assign oBCD    = bcd_q;
  assign oNEG    = neg_q;
  assign oERR    = err_q;

endmodule

// File: tb/tb_calc_seq_core.sv
// Scoreboard bench for calc_seq_core: a predictor models start acceptance
// and pushes expected results; a monitor checks them when oDONE appears and
// checks held outputs and oBUSY every cycle.
module tb_calc_seq_core;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned OP_MAX     = 99;
  localparam int unsigned RES_DIGITS = 4;
  localparam int L_SHORT = 1 + 2 * OP_W;
  localparam int L_LONG  = 3 * OP_W;

  logic                    iCLK;
  logic                    iRST;
  logic                    iSTART;
  logic [OP_W-1:0]         iA;
  logic [OP_W-1:0]         iB;
  logic [1:0]              iOP;
  logic                    oBUSY;
  logic                    oDONE;
  logic [2*OP_W-1:0]       oRESULT;
  logic [OP_W-1:0]         oREM;
  logic [4*RES_DIGITS-1:0] oBCD;
  logic                    oNEG;
  logic                    oERR;

  calc_seq_core #(.OP_W(OP_W), .OP_MAX(OP_MAX), .RES_DIGITS(RES_DIGITS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iA(iA), .iB(iB), .iOP(iOP),
    .oBUSY(oBUSY), .oDONE(oDONE), .oRESULT(oRESULT), .oREM(oREM), .oBCD(oBCD),
    .oNEG(oNEG), .oERR(oERR)
  );

  typedef struct {
    logic [13:0] res;
    logic [6:0]  rem;
    logic [15:0] bcd;
    logic        neg;
    logic        err;
    int          done_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t shown;
  exp_t zero_e;
  exp_t pe_p;
  exp_t pe_m;
  int   cyc        = 0;
  int   idle_from  = 0;
  int   busy_until = -1;
  int   n_checks   = 0;
  int   n_pass     = 0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: clip, compute with plain integer arithmetic, decimal digits for BCD
  function automatic exp_t model(input int a_raw, input int b_raw, input int op);
    exp_t e;
    int a, b, r, rm, lat, tmp;
    a = (a_raw > int'(OP_MAX)) ? int'(OP_MAX) : a_raw;
    b = (b_raw > int'(OP_MAX)) ? int'(OP_MAX) : b_raw;
    r = 0; rm = 0; lat = L_SHORT;
    e.neg = 1'b0; e.err = 1'b0;
    case (op)
      0: r = a + b;
      1: if (a < b) begin r = b - a; e.neg = 1'b1; end else r = a - b;
      2: begin r = a * b; lat = L_LONG; end
      default: if (b == 0) e.err = 1'b1;
               else begin r = a / b; rm = a % b; lat = L_LONG; end
    endcase
    e.res = 14'(r);
    e.rem = 7'(rm);
    e.bcd = 16'h0;
    if (e.err) e.bcd = 16'hFFFF;
    else begin
      tmp = r;
      for (int i = 0; i < 4; i++) begin
        e.bcd = e.bcd | (16'(tmp % 10) << (4 * i));
        tmp = tmp / 10;
      end
    end
    e.done_edge = lat;
    return e;
  endfunction

  // Predictor: decides which starts are accepted and when each completes
  initial begin
    forever begin
      @(posedge iCLK);
      cyc++;
      if (iRST) begin
        idle_from  = cyc + 1;
        busy_until = -1;
      end else if (iSTART && cyc >= idle_from) begin
        pe_p = model(int'(iA), int'(iB), int'(iOP));
        pe_p.done_edge = cyc + pe_p.done_edge;
        busy_until = pe_p.done_edge;
        idle_from  = pe_p.done_edge + 2;
        sb_q.push_back(pe_p);
      end
    end
  end

  // Monitor: compare outputs on the falling edge
  initial begin
    zero_e = '{res: '0, rem: '0, bcd: '0, neg: 1'b0, err: 1'b0, done_edge: 0};
    shown  = zero_e;
    forever begin
      @(negedge iCLK);
      check("busy", 64'(oBUSY), 64'(cyc <= busy_until));
      if (oDONE) begin
        if (sb_q.size() == 0) check("unexpected_done", 64'(oDONE), 64'(0));
        else begin
          pe_m = sb_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(pe_m.done_edge));
          check("result", 64'(oRESULT), 64'(pe_m.res));
          check("rem", 64'(oREM), 64'(pe_m.rem));
          check("bcd", 64'(oBCD), 64'(pe_m.bcd));
          check("neg", 64'(oNEG), 64'(pe_m.neg));
          check("err", 64'(oERR), 64'(pe_m.err));
          shown = pe_m;
        end
      end else begin
        if (sb_q.size() != 0 && sb_q[0].done_edge == cyc) begin
          check("done_missing", 64'(oDONE), 64'(1));
          shown = sb_q.pop_front();
        end
        check("held_outputs", 64'({oRESULT, oREM, oBCD, oNEG, oERR}),
              64'({shown.res, shown.rem, shown.bcd, shown.neg, shown.err}));
      end
      if (iRST) begin
        sb_q.delete();
        shown = zero_e;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic run(input int a, input int b, input int op);
    iA = 7'(a); iB = 7'(b); iOP = 2'(op);
    iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
    tick(L_LONG + 3);
  endtask

  // Stimulus
  initial begin
    int ra, rb, ro;
    iRST = 1'b1; iSTART = 1'b0; iA = '0; iB = '0; iOP = '0;
    tick(2);
    iRST = 1'b0;
    tick(1);

    run(120, 45, 0);
    run(3, 12, 1);
    run(12, 3, 1);
    run(99, 99, 2);
    run(97, 8, 3);
    run(0, 99, 3);
    run(50, 0, 3);
    run(10, 20, 0);

    // iSTART held high: one op, then the next one right after returning to IDLE
    iA = 7'd99; iB = 7'd99; iOP = 2'd2; iSTART = 1'b1;
    tick(45);
    iSTART = 1'b0;
    tick(30);

    // Start pulse while busy must be ignored
    iA = 7'd99; iB = 7'd98; iOP = 2'd2; iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
    tick(4);
    iA = 7'd5; iB = 7'd5; iOP = 2'd0; iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
    tick(L_LONG + 3);

    // Reset in the middle of a mul abandons it
    iA = 7'd99; iB = 7'd97; iOP = 2'd2; iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
    tick(9);
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    tick(30);
    run(45, 67, 2);

    repeat (40) begin
      ra = int'($urandom_range(0, 127));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
      ro = int'($urandom_range(0, 3));
      run(ra, rb, ro);
    end

    tick(5);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
